// File: rtl/sopc_bus_arbiter.sv
// sopc_bus_arbiter: N-master to one-slave arbiter with fixed slave latency and one-cycle acks.
// Define SOPC_ARB_ROUND_ROBIN_EN for round-robin grants; otherwise the lowest index wins.
`default_nettype none

module sopc_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            m_req_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_sel_i,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [DATA_WIDTH-1:0]             m_rdata_o,
  output logic [NUM_MASTERS-1:0]            gnt_o,
  output logic                              s_ce_o,
  output logic                              s_we_o,
  output logic [ADDR_WIDTH-1:0]             s_addr_o,
  output logic [DATA_WIDTH-1:0]             s_wdata_o,
  output logic [DATA_WIDTH/8-1:0]           s_sel_o,
  input  logic [DATA_WIDTH-1:0]             s_rdata_i
);

  localparam int SEL_W = DATA_WIDTH / 8;
  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [NUM_MASTERS-1:0] gnt_q;
  logic [NUM_MASTERS-1:0] ack_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic                   s_ce_q;
  logic                   s_we_q;
  logic [ADDR_WIDTH-1:0]  s_addr_q;
  logic [DATA_WIDTH-1:0]  s_wdata_q;
  logic [SEL_W-1:0]       s_sel_q;

  logic                   found_d;
  logic [IDX_W-1:0]       win_d;

`ifdef SOPC_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W:0]   cand;

  // Search starts at the pointer and wraps modulo NUM_MASTERS.
  always_comb begin
    found_d = 1'b0;
    win_d   = '0;
    cand    = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_MASTERS)) begin
        cand = cand - (IDX_W+1)'(NUM_MASTERS);
      end
      if (!found_d && m_req_i[cand[IDX_W-1:0]]) begin
        found_d = 1'b1;
        win_d   = cand[IDX_W-1:0];
      end
    end
    ptr_d = (win_d == IDX_W'(NUM_MASTERS - 1)) ? '0 : win_d + 1'b1;
  end
`else
  always_comb begin
    found_d = 1'b0;
    win_d   = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!found_d && m_req_i[k[IDX_W-1:0]]) begin
        found_d = 1'b1;
        win_d   = k[IDX_W-1:0];
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      gnt_q     <= '0;
      ack_q     <= '0;
      rdata_q   <= '0;
      s_ce_q    <= 1'b0;
      s_we_q    <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_sel_q   <= '0;
`ifdef SOPC_ARB_ROUND_ROBIN_EN
      ptr_q     <= '0;
`endif
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (found_d) begin
            state_q   <= ACCESS;
            cnt_q     <= '0;
            gnt_q     <= NUM_MASTERS'(1) << win_d;
            s_ce_q    <= 1'b1;
            s_we_q    <= m_we_i[win_d];
            s_addr_q  <= m_addr_i[win_d*ADDR_WIDTH +: ADDR_WIDTH];
            s_wdata_q <= m_wdata_i[win_d*DATA_WIDTH +: DATA_WIDTH];
            s_sel_q   <= m_sel_i[win_d*SEL_W +: SEL_W];
`ifdef SOPC_ARB_ROUND_ROBIN_EN
            ptr_q     <= ptr_d;
`endif
          end
        end
        ACCESS: begin
          cnt_q <= cnt_q + 1'b1;
          // Last slave cycle: the latched s_we_q decides whether read data is kept.
          if (cnt_q == CNT_W'(WAIT_STATES)) begin
            if (!s_we_q) begin
              rdata_q <= s_rdata_i;
            end
            state_q   <= DONE;
            ack_q     <= gnt_q;
            gnt_q     <= '0;
            s_ce_q    <= 1'b0;
            s_we_q    <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_sel_q   <= '0;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m_ack_o   = ack_q;
  assign m_rdata_o = rdata_q;
  assign gnt_o     = gnt_q;
  assign s_ce_o    = s_ce_q;
  assign s_we_o    = s_we_q;
  assign s_addr_o  = s_addr_q;
  assign s_wdata_o = s_wdata_q;
  assign s_sel_o   = s_sel_q;

endmodule

`default_nettype wire

// File: tb/tb_sopc_bus_arbiter.sv
// tb_sopc_bus_arbiter: directed checks on three arbiters (WAIT_STATES = 1, 3, 0) sharing stimulus.
`default_nettype none

module tb_sopc_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, we;
  logic [63:0] addr, wdata;
  logic [7:0]  sel;
  logic [31:0] srdata;

  logic [1:0]  ack_a, gnt_a, ack_b, gnt_b, ack_c, gnt_c;
  logic [31:0] rdata_a, rdata_b, rdata_c;
  logic        ce_a, ce_b, ce_c, we_a, we_b, we_c;
  logic [31:0] addr_a, addr_b, addr_c, wd_a, wd_b, wd_c;
  logic [3:0]  sel_a, sel_b, sel_c;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sopc_bus_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_STATES(1)) u_a (
    .clk(clk), .rst(rst), .m_req_i(req), .m_we_i(we), .m_addr_i(addr), .m_wdata_i(wdata),
    .m_sel_i(sel), .m_ack_o(ack_a), .m_rdata_o(rdata_a), .gnt_o(gnt_a), .s_ce_o(ce_a),
    .s_we_o(we_a), .s_addr_o(addr_a), .s_wdata_o(wd_a), .s_sel_o(sel_a), .s_rdata_i(srdata)
  );

  sopc_bus_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_STATES(3)) u_b (
    .clk(clk), .rst(rst), .m_req_i(req), .m_we_i(we), .m_addr_i(addr), .m_wdata_i(wdata),
    .m_sel_i(sel), .m_ack_o(ack_b), .m_rdata_o(rdata_b), .gnt_o(gnt_b), .s_ce_o(ce_b),
    .s_we_o(we_b), .s_addr_o(addr_b), .s_wdata_o(wd_b), .s_sel_o(sel_b), .s_rdata_i(srdata)
  );

  sopc_bus_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_STATES(0)) u_c (
    .clk(clk), .rst(rst), .m_req_i(req), .m_we_i(we), .m_addr_i(addr), .m_wdata_i(wdata),
    .m_sel_i(sel), .m_ack_o(ack_c), .m_rdata_o(rdata_c), .gnt_o(gnt_c), .s_ce_o(ce_c),
    .s_we_o(we_c), .s_addr_o(addr_c), .s_wdata_o(wd_c), .s_sel_o(sel_c), .s_rdata_i(srdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 2'b00;
    we  = 2'b00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    addr = '0; wdata = '0; sel = '0; srdata = '0;
    do_reset();
    vectors++; if ({ack_a, gnt_a, ce_a, we_a} !== 6'b0) begin miscompares++; $display("FAIL reset_ctrl_a got=%b exp=0", {ack_a, gnt_a, ce_a, we_a}); end
    vectors++; if ({addr_a, wd_a, sel_a} !== 68'h0) begin miscompares++; $display("FAIL reset_bus_a got=%h exp=0", {addr_a, wd_a, sel_a}); end
    vectors++; if (rdata_a !== 32'h0) begin miscompares++; $display("FAIL reset_rdata_a got=%h exp=0", rdata_a); end
    vectors++; if ({ack_b, gnt_b, ce_b, ack_c, gnt_c, ce_c} !== 10'b0) begin miscompares++; $display("FAIL reset_ctrl_bc got=%b exp=0", {ack_b, gnt_b, ce_b, ack_c, gnt_c, ce_c}); end
  endtask

  task automatic test_single_read();
    do_reset();
    srdata = 32'hDEADBEEF;
    addr[31:0] = 32'h100;
    we  = 2'b00;
    req = 2'b01;
    tick();
    req = 2'b00;
    vectors++; if ({ce_a, we_a, gnt_a, ack_a} !== 6'b1_0_01_00) begin miscompares++; $display("FAIL read_acc1 got=%b exp=100100", {ce_a, we_a, gnt_a, ack_a}); end
    vectors++; if (addr_a !== 32'h100) begin miscompares++; $display("FAIL read_addr got=%h exp=100", addr_a); end
    tick();
    vectors++; if ({ce_a, ack_a} !== 3'b1_00) begin miscompares++; $display("FAIL read_acc2 got=%b exp=100", {ce_a, ack_a}); end
    tick();
    vectors++; if ({ce_a, gnt_a, ack_a} !== 5'b0_00_01) begin miscompares++; $display("FAIL read_done got=%b exp=00001", {ce_a, gnt_a, ack_a}); end
    vectors++; if (rdata_a !== 32'hDEADBEEF) begin miscompares++; $display("FAIL read_rdata got=%h exp=deadbeef", rdata_a); end
    vectors++; if (addr_a !== 32'h0) begin miscompares++; $display("FAIL read_addr_idle got=%h exp=0", addr_a); end
    tick();
    vectors++; if (ack_a !== 2'b00) begin miscompares++; $display("FAIL read_ack_once got=%b exp=00", ack_a); end
  endtask

  task automatic test_byte_write();
    srdata = 32'hCAFEF00D;
    addr[63:32]  = 32'h20;
    wdata[63:32] = 32'h12345678;
    sel[7:4]     = 4'b0011;
    we  = 2'b10;
    req = 2'b10;
    tick();
    addr[63:32] = 32'h999;
    sel[7:4]    = 4'b1111;
    we  = 2'b00;
    req = 2'b00;
    vectors++; if ({ce_a, we_a, sel_a, gnt_a} !== 8'b1_1_0011_10) begin miscompares++; $display("FAIL wr_acc1 got=%b exp=11001110", {ce_a, we_a, sel_a, gnt_a}); end
    vectors++; if ({addr_a, wd_a} !== {32'h20, 32'h12345678}) begin miscompares++; $display("FAIL wr_bus got=%h exp=0000002012345678", {addr_a, wd_a}); end
    tick();
    vectors++; if ({ce_a, we_a, sel_a, addr_a} !== {1'b1, 1'b1, 4'b0011, 32'h20}) begin miscompares++; $display("FAIL wr_acc2_hold got=%h exp=%h", {ce_a, we_a, sel_a, addr_a}, {1'b1, 1'b1, 4'b0011, 32'h20}); end
    tick();
    vectors++; if ({ce_a, we_a, ack_a} !== 4'b0_0_10) begin miscompares++; $display("FAIL wr_done got=%b exp=0010", {ce_a, we_a, ack_a}); end
    vectors++; if (rdata_a !== 32'hDEADBEEF) begin miscompares++; $display("FAIL wr_rdata_kept got=%h exp=deadbeef", rdata_a); end
    tick();
    vectors++; if (ack_a !== 2'b00) begin miscompares++; $display("FAIL wr_ack_once got=%b exp=00", ack_a); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_ack, exp_gnt, who;
    do_reset();
    we  = 2'b00;
    req = 2'b11;
    for (int i = 1; i <= 16; i++) begin
      tick();
`ifdef SOPC_ARB_ROUND_ROBIN_EN
      who = ((i / 4) % 2 == 0) ? 2'b01 : 2'b10;
`else
      who = 2'b01;
`endif
      exp_ack = (i % 4 == 3) ? who : 2'b00;
      exp_gnt = (i % 4 == 1 || i % 4 == 2) ? who : 2'b00;
      vectors++; if (ack_a !== exp_ack) begin miscompares++; $display("FAIL contend_ack cyc=%0d got=%b exp=%b", i, ack_a, exp_ack); end
      vectors++; if (gnt_a !== exp_gnt) begin miscompares++; $display("FAIL contend_gnt cyc=%0d got=%b exp=%b", i, gnt_a, exp_gnt); end
    end
    req = 2'b00;
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    srdata = 32'h55AA55AA;
    addr[31:0] = 32'h40;
    we  = 2'b00;
    req = 2'b01;
    for (int i = 1; i <= 6; i++) begin
      tick();
      req = 2'b00;
      vectors++; if (ce_b !== (i <= 4)) begin miscompares++; $display("FAIL w3_ce cyc=%0d got=%b exp=%b", i, ce_b, (i <= 4)); end
      vectors++; if (ack_b !== ((i == 5) ? 2'b01 : 2'b00)) begin miscompares++; $display("FAIL w3_ack cyc=%0d got=%b", i, ack_b); end
    end
    vectors++; if (rdata_b !== 32'h55AA55AA) begin miscompares++; $display("FAIL w3_rdata got=%h exp=55aa55aa", rdata_b); end
    addr[31:0] = 32'h44;
    req = 2'b01;
    tick();
    req = 2'b00;
    tick();
    rst = 1'b1;
    tick();
    vectors++; if ({ce_b, we_b, gnt_b, ack_b} !== 6'b0) begin miscompares++; $display("FAIL rstmid_ctrl got=%b exp=0", {ce_b, we_b, gnt_b, ack_b}); end
    vectors++; if ({rdata_b, addr_b, sel_b} !== 68'h0) begin miscompares++; $display("FAIL rstmid_data got=%h exp=0", {rdata_b, addr_b, sel_b}); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++; if ({ack_b, ce_b} !== 3'b0) begin miscompares++; $display("FAIL rstmid_noack cyc=%0d got=%b exp=0", i, {ack_b, ce_b}); end
    end
    srdata = 32'h13579BDF;
    req = 2'b11;
    for (int i = 1; i <= 6; i++) begin
      tick();
      req = 2'b00;
      if (i == 1) begin
        vectors++; if (gnt_b !== 2'b01) begin miscompares++; $display("FAIL rstmid_regrant got=%b exp=01", gnt_b); end
      end
      vectors++; if (ce_b !== (i <= 4)) begin miscompares++; $display("FAIL rstmid_ce cyc=%0d got=%b exp=%b", i, ce_b, (i <= 4)); end
      vectors++; if (ack_b !== ((i == 5) ? 2'b01 : 2'b00)) begin miscompares++; $display("FAIL rstmid_ack cyc=%0d got=%b", i, ack_b); end
    end
    vectors++; if (rdata_b !== 32'h13579BDF) begin miscompares++; $display("FAIL rstmid_rdata got=%h exp=13579bdf", rdata_b); end
  endtask

  task automatic test_zero_wait();
    do_reset();
    srdata = 32'h0BADCAFE;
    addr[31:0] = 32'h8;
    we  = 2'b00;
    req = 2'b01;
    tick();
    req = 2'b00;
    vectors++; if ({ce_c, gnt_c, ack_c} !== 5'b1_01_00) begin miscompares++; $display("FAIL w0_acc got=%b exp=10100", {ce_c, gnt_c, ack_c}); end
    tick();
    vectors++; if ({ce_c, gnt_c, ack_c} !== 5'b0_00_01) begin miscompares++; $display("FAIL w0_done got=%b exp=00001", {ce_c, gnt_c, ack_c}); end
    vectors++; if (rdata_c !== 32'h0BADCAFE) begin miscompares++; $display("FAIL w0_rdata got=%h exp=0badcafe", rdata_c); end
    tick();
    vectors++; if ({ce_c, ack_c} !== 3'b0) begin miscompares++; $display("FAIL w0_idle got=%b exp=000", {ce_c, ack_c}); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_byte_write();
    test_contention();
    test_reset_mid_access();
    test_zero_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sopc_bus_arbiter.md
# sopc_bus_arbiter

Parametrised N-master to one-slave bus arbiter for the minimal SOPC. It replaces the direct core-to-ROM wiring so that instruction fetch, data access and further masters can share one synchronous memory. Each access gets a fixed slave latency, and each master receives a one-cycle acknowledge. Grant policy is round-robin or fixed priority, selected at compile time.

## Interface
Parameters:
- NUM_MASTERS, 2, number of master ports (≥1)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width (multiple of 8)
- WAIT_STATES, 1, extra slave cycles per access (≥0)

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- m_req_i  in  NUM_MASTERS  per-master access request; held until ack
- m_we_i  in  NUM_MASTERS  per-master write enable (1=write)
- m_addr_i  in  NUM_MASTERS*ADDR_WIDTH  packed addresses; master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- m_wdata_i  in  NUM_MASTERS*DATA_WIDTH  packed write data
- m_sel_i  in  NUM_MASTERS*DATA_WIDTH/8  packed byte selects
- m_ack_o  out  NUM_MASTERS  one-cycle completion pulse to the granted master
- m_rdata_o  out  DATA_WIDTH  read data, shared by all masters, registered
- gnt_o  out  NUM_MASTERS  one-hot current grant; 0 when idle
- s_ce_o  out  1  slave chip enable
- s_we_o  out  1  slave write enable
- s_addr_o  out  ADDR_WIDTH  slave address
- s_wdata_o  out  DATA_WIDTH  slave write data
- s_sel_o  out  DATA_WIDTH/8  slave byte selects
- s_rdata_i  in  DATA_WIDTH  slave read data; valid in the last ACCESS cycle

## Operation
FSM states are IDLE, ACCESS and DONE.
- **IDLE:** if any m_req_i bit is set, pick a winner and go to ACCESS.
  - On the same edge, latch the winner's we/addr/wdata/sel, set gnt_o, and clear the wait counter.
- **ACCESS:**
  - s_ce_o=1. s_we_o, s_addr_o, s_wdata_o and s_sel_o come from the latched values.
  - The counter increments each cycle.
  - When counter==WAIT_STATES, capture s_rdata_i into m_rdata_o (reads only) and go to DONE.
- **DONE:**
  - m_ack_o[winner]=1 for exactly this cycle.
  - s_ce_o=0, gnt_o cleared, return to IDLE. Arbitration happens only in IDLE.

Rules:
- All s_* outputs are 0 outside ACCESS.
- m_rdata_o holds its value between reads and is unchanged by writes.
- Master inputs are sampled only at grant. Changes mid-transaction have no effect.
- If a master drops m_req_i before its ack, the access still completes, the write is committed, and the ack still pulses.
- After the ack, a master that keeps m_req_i high is treated as issuing a new request.
- Wait counter width is clog2(WAIT_STATES+1), minimum 1 bit.
- Reset (any state):
  - Next state IDLE; in-flight access aborted with no ack.
  - All outputs 0, m_rdata_o=0, priority pointer=0.

## Timing
- Request seen in IDLE at cycle t with no other owner:
  - s_ce_o high in cycles t+1 … t+1+WAIT_STATES.
  - m_ack_o and the new m_rdata_o are visible at t+2+WAIT_STATES.
- Access length is WAIT_STATES+3 cycles from request to the next possible grant. With WAIT_STATES=1, the ack arrives 3 cycles after the request.
- Simultaneous requests: exactly one grant per arbitration. The others wait in IDLE until a later arbitration.

## Configuration
- SOPC_ARB_ROUND_ROBIN_EN defined (round-robin):
  - The search starts at the priority pointer, wrapping modulo NUM_MASTERS.
  - After granting master i, pointer=(i+1) mod NUM_MASTERS. The pointer updates at grant.
- SOPC_ARB_ROUND_ROBIN_EN undefined (fixed priority):
  - The lowest-index requesting master always wins.
  - The pointer logic is not instantiated.

## Test plan
- **Single read:** N=2, W=1; m0 reads 0x100, slave returns 0xDEADBEEF.
  - s_ce_o high 2 cycles with s_addr_o=0x100.
  - m_ack_o=2'b01 at t+3, m_rdata_o=0xDEADBEEF.
- **Byte write:** m1 writes 0x12345678, sel=4'b0011, to 0x20.
  - s_we_o=1, s_sel_o=4'b0011 throughout ACCESS.
  - m_ack_o=2'b10 once; m_rdata_o unchanged.
- **Round-robin contention:** with the macro defined, m0 and m1 request continuously from reset.
  - Grants alternate m0, m1, m0, m1, each ack WAIT_STATES+3 cycles apart.
- **Fixed-priority contention:** with the macro undefined, the same stimulus gives only m0 grants; m1 is never acked while m0 keeps requesting.
- **Reset mid-access:** W=3; assert rst in the 2nd ACCESS cycle.
  - Next cycle all outputs are 0 and there is no ack.
  - A fresh request is served normally, granted to m0 first.
- **Zero wait states:** W=0; s_ce_o is high exactly 1 cycle and the ack arrives at t+2.
